fetch_stage: RTL

Instruction-fetch stage of the five-stage pipeline, directly upstream of the decode-stage control unit. It owns the program counter and drives instruction-memory addresses. It holds the IF/ID pipeline register that presents each instruction word to decode. When decode asserts `flush` for a two-word LDM, this stage captures the following word as the immediate and puts a NOP bubble into IF/ID in place of that word.

---
 rtl/pipeline_pkg.sv | 26 ++
 rtl/fetch_stage_if_id_reg.sv | 34 +++
 rtl/fetch_stage.sv | 101 ++++++++++
 3 files changed

// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: opcode constants, instruction field bounds, NOP word, fetch FSM states.
package pipeline_pkg;

  localparam int INSTR_W = 16;
  localparam int OPC_HI  = 15;
  localparam int OPC_LO  = 10;
  localparam int OPC_W   = OPC_HI - OPC_LO + 1;

  localparam logic [OPC_W-1:0] OPC_NOP = 6'b000001;
  localparam logic [OPC_W-1:0] OPC_NOT = 6'b000010;
  localparam logic [OPC_W-1:0] OPC_ADD = 6'b000011;
  localparam logic [OPC_W-1:0] OPC_LDM = 6'b000100;
  localparam logic [OPC_W-1:0] OPC_STD = 6'b000101;

  localparam logic [INSTR_W-1:0] NOP_WORD = {OPC_NOP, {(INSTR_W-OPC_W){1'b0}}};

  typedef enum logic {
    ST_BOOT  = 1'b0,
    ST_FETCH = 1'b1
  } fetch_state_t;

  function automatic logic [OPC_W-1:0] opcode_of(input logic [INSTR_W-1:0] instr);
    return instr[OPC_HI:OPC_LO];
  endfunction

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register: holds on i_hold, substitutes the bubble word on i_bubble.
// One-cycle register; i_hold has priority over i_bubble, reset loads the bubble word.
module if_id_reg #(
  parameter int PC_W = 32,
  parameter int INSTR_W = 16,
  parameter logic [INSTR_W-1:0] BUBBLE_WORD = 16'h0400
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_hold,
  input  logic               i_bubble,
  input  logic [INSTR_W-1:0] i_instr,
  input  logic [PC_W-1:0]    i_pc,
  output logic [INSTR_W-1:0] o_instr,
  output logic [PC_W-1:0]    o_pc
);

  logic [INSTR_W-1:0] r_instr;
  logic [PC_W-1:0]    r_pc;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_instr <= BUBBLE_WORD;
      r_pc    <= '0;
    end else if (!i_hold) begin
      r_instr <= i_bubble ? BUBBLE_WORD : i_instr;
      r_pc    <= i_pc;
    end
  end

  assign o_instr = r_instr;
  assign o_pc    = r_pc;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC, BOOT/FETCH control, LDM immediate capture, IF/ID register toward decode.
// Build option FETCH_RESET_VECTOR_EN: BOOT loads the PC from word 0 (reset vector) instead of 0.
module fetch_stage #(
  parameter int PC_W = 32,
  parameter int INSTR_W = 16,
  parameter logic [5:0] NOP_OPCODE = 6'b000001
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall,
  input  logic               cu_flush,
  input  logic [INSTR_W-1:0] imem_data,
  output logic [PC_W-1:0]    imem_addr,
  output logic [INSTR_W-1:0] if_id_instr,
  output logic [PC_W-1:0]    if_id_pc,
  output logic [INSTR_W-1:0] imm_out,
  output logic               imm_valid
);
  import pipeline_pkg::*;

  localparam logic [INSTR_W-1:0] BUBBLE = {NOP_OPCODE, {(INSTR_W-OPC_W){1'b0}}};
  localparam logic [PC_W-1:0]    PC_ONE = {{(PC_W-1){1'b0}}, 1'b1};

  fetch_state_t       r_state;
  fetch_state_t       w_state_nxt;
  logic [PC_W-1:0]    r_pc;
  logic [PC_W-1:0]    w_pc_nxt;
  logic [INSTR_W-1:0] r_imm;
  logic               r_imm_vld;
  logic               w_bubble;
  logic               w_capture;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_BOOT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Stall freezes everything; cu_flush is re-evaluated once the stall releases.
  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_bubble    = 1'b0;
    w_capture   = 1'b0;
    if (!stall) begin
      case (r_state)
        ST_BOOT: begin
          w_state_nxt = ST_FETCH;
          w_bubble    = 1'b1;
`ifdef FETCH_RESET_VECTOR_EN
          w_pc_nxt    = PC_W'(imem_data);
`else
          w_pc_nxt    = '0;
`endif
        end
        ST_FETCH: begin
          w_pc_nxt  = r_pc + PC_ONE;
          w_bubble  = cu_flush;
          w_capture = cu_flush;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc      <= '0;
      r_imm     <= '0;
      r_imm_vld <= 1'b0;
    end else begin
      r_pc      <= w_pc_nxt;
      r_imm_vld <= w_capture;
      if (w_capture) begin
        r_imm <= imem_data;
      end
    end
  end

  // The word fetched under a flush is the LDM immediate; decode sees a bubble in its place.
  if_id_reg #(
    .PC_W       (PC_W),
    .INSTR_W    (INSTR_W),
    .BUBBLE_WORD(BUBBLE)
  ) u_if_id (
    .clk     (clk),
    .rst     (rst),
    .i_hold  (stall),
    .i_bubble(w_bubble),
    .i_instr (imem_data),
    .i_pc    (r_pc),
    .o_instr (if_id_instr),
    .o_pc    (if_id_pc)
  );

  assign imem_addr = r_pc;
  assign imm_out   = r_imm;
  assign imm_valid = r_imm_vld;

endmodule
